// File: rtl/customer_pkg.sv
// Shared types and default widths for the vending-machine customer purchase unit.
package customer_pkg;

  localparam int unsigned PRICE_W_DEF   = 4;
  localparam int unsigned AMT_W_DEF     = 4;
  localparam int unsigned MONEY_W_DEF   = 7;
  localparam int unsigned ACC_W_DEF     = 9;
  localparam int unsigned ACC_OUT_W_DEF = 5;

  localparam logic [1:0] MODE_CUSTOMER = 2'd1;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_e;

endpackage

// File: rtl/customer_sale_check.sv
// Combinational purchase validation: full-width cost and the accept decision.
module customer_sale_check #(
  parameter int unsigned PRICE_W = 4,
  parameter int unsigned AMT_W   = 4,
  parameter int unsigned MONEY_W = 7
) (
  input  logic [PRICE_W-1:0]       price,
  input  logic [AMT_W-1:0]         amount,
  input  logic [MONEY_W-1:0]       money,
  input  logic [AMT_W-1:0]         supply,
  output logic [PRICE_W+AMT_W-1:0] cost,
  output logic                     accept
);

  localparam int unsigned CostW = PRICE_W + AMT_W;
  localparam int unsigned CmpW  = (CostW > MONEY_W) ? CostW : MONEY_W;

  logic [CmpW-1:0] money_ext;
  logic [CmpW-1:0] cost_ext;

  // Product of PRICE_W and AMT_W bits never overflows CostW bits.
  assign cost = CostW'(price) * CostW'(amount);

  always_comb begin
    money_ext = CmpW'(money);
    cost_ext  = CmpW'(cost);
    accept    = (amount != '0) && (amount <= supply) && (money_ext >= cost_ext);
  end

endmodule

// File: rtl/customer.sv
// Customer purchase transaction unit: captures a request in customer mode, validates it and
// registers the updated stock and account, or raises redLight and passes them through unchanged.
module customer
  import customer_pkg::*;
#(
  parameter int unsigned PRICE_W   = PRICE_W_DEF,
  parameter int unsigned AMT_W     = AMT_W_DEF,
  parameter int unsigned MONEY_W   = MONEY_W_DEF,
  parameter int unsigned ACC_W     = ACC_W_DEF,
  parameter int unsigned ACC_OUT_W = ACC_OUT_W_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [1:0]           mode,
  input  logic [PRICE_W-1:0]   price,
  input  logic [AMT_W-1:0]     amount,
  input  logic [MONEY_W-1:0]   money,
  input  logic [ACC_W-1:0]     mahcineAcc,
  input  logic [AMT_W-1:0]     supply,
  output logic                 redLight,
  output logic [ACC_OUT_W-1:0] machineAcc_out,
  output logic [AMT_W-1:0]     supply_out
);

  localparam int unsigned CostW = PRICE_W + AMT_W;
  localparam int unsigned SumW  = ((ACC_W > CostW) ? ACC_W : CostW) + 1;

  state_e state_q, state_d;

  logic [PRICE_W-1:0] price_q;
  logic [AMT_W-1:0]   amount_q;
  logic [MONEY_W-1:0] money_q;
  logic [ACC_W-1:0]   acc_q;
  logic [AMT_W-1:0]   supply_q;

  logic             capture;
  logic             load_result;
  logic [CostW-1:0] cost;
  logic             accept;
  logic [SumW-1:0]  acc_sum;
  logic [AMT_W-1:0] supply_left;
  logic             unused_sum_hi;

  customer_sale_check #(
    .PRICE_W (PRICE_W),
    .AMT_W   (AMT_W),
    .MONEY_W (MONEY_W)
  ) u_sale_check (
    .price  (price_q),
    .amount (amount_q),
    .money  (money_q),
    .supply (supply_q),
    .cost   (cost),
    .accept (accept)
  );

  // Only the low ACC_OUT_W bits of the sum leave the block.
  assign acc_sum       = SumW'(acc_q) + SumW'(cost);
  assign unused_sum_hi = ^acc_sum[SumW-1:ACC_OUT_W];
  assign supply_left   = supply_q - amount_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (mode == MODE_CUSTOMER) state_d = CALC;
      CALC:    state_d = (mode == MODE_CUSTOMER) ? DONE : IDLE;
      DONE:    if (mode != MODE_CUSTOMER) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    capture     = (state_q == IDLE) && (mode == MODE_CUSTOMER);
    load_result = (state_q == CALC) && (mode == MODE_CUSTOMER);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      price_q  <= '0;
      amount_q <= '0;
      money_q  <= '0;
      acc_q    <= '0;
      supply_q <= '0;
    end else if (capture) begin
      price_q  <= price;
      amount_q <= amount;
      money_q  <= money;
      acc_q    <= mahcineAcc;
      supply_q <= supply;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      redLight       <= 1'b0;
      machineAcc_out <= '0;
      supply_out     <= '0;
    end else if (load_result) begin
      if (accept) begin
        redLight       <= 1'b0;
        supply_out     <= supply_left;
        machineAcc_out <= acc_sum[ACC_OUT_W-1:0];
      end else begin
        redLight       <= 1'b1;
        supply_out     <= supply_q;
        machineAcc_out <= acc_q[ACC_OUT_W-1:0];
      end
    end
  end

endmodule

// File: tb/tb_customer.sv
// Scoreboard bench for customer: stimulus queues expected results, a monitor compares them.
module tb_customer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] mode = 2'd0;
  logic [3:0] price = '0;
  logic [3:0] amount = '0;
  logic [6:0] money = '0;
  logic [8:0] mahcineAcc = '0;
  logic [3:0] supply = '0;
  logic       redLight;
  logic [4:0] machineAcc_out;
  logic [3:0] supply_out;

  customer dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .mode           (mode),
    .price          (price),
    .amount         (amount),
    .money          (money),
    .mahcineAcc     (mahcineAcc),
    .supply         (supply),
    .redLight       (redLight),
    .machineAcc_out (machineAcc_out),
    .supply_out     (supply_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    int red;
    int sup;
    int acc;
    int due;
  } exp_t;

  exp_t q[$];
  exp_t cur = '{0, 0, 0, 0};
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Reference: price*amount must be covered by money and stock, nonzero quantity.
  function automatic exp_t model(input int p, input int a, input int m, input int acc,
                                 input int s, input int due);
    exp_t e;
    int cost;
    cost = p * a;
    if (a == 0 || a > s || m < cost) begin
      e.red = 1; e.sup = s; e.acc = acc % 32;
    end else begin
      e.red = 0; e.sup = s - a; e.acc = (acc + cost) % 32;
    end
    e.due = due;
    return e;
  endfunction

  always @(negedge clk) begin
    if (!rst_n) begin
      cur = '{0, 0, 0, 0};
    end else if (q.size() > 0 && q[0].due == cyc) begin
      cur = q.pop_front();
      check("txn_red", int'(redLight), cur.red);
      check("txn_supply", int'(supply_out), cur.sup);
      check("txn_acc", int'(machineAcc_out), cur.acc);
    end else begin
      check("hold_red", int'(redLight), cur.red);
      check("hold_supply", int'(supply_out), cur.sup);
      check("hold_acc", int'(machineAcc_out), cur.acc);
    end
  end

  function automatic logic [1:0] other_mode();
    int r;
    r = $urandom_range(0, 2);
    return (r == 0) ? 2'd0 : (r == 1) ? 2'd2 : 2'd3;
  endfunction

  task automatic purchase(input int p, input int a, input int m, input int acc, input int s,
                          input int hold);
    @(negedge clk);
    price = 4'(p); amount = 4'(a); money = 7'(m); mahcineAcc = 9'(acc); supply = 4'(s);
    mode = 2'd1;
    q.push_back(model(p, a, m, acc, s, cyc + 2));
    // Post-capture input churn must not disturb the transaction in flight.
    for (int i = 1; i < hold; i++) begin
      @(negedge clk);
      price = 4'($urandom); amount = 4'($urandom); money = 7'($urandom);
      mahcineAcc = 9'($urandom); supply = 4'($urandom);
    end
    @(negedge clk);
    mode = other_mode();
    repeat ($urandom_range(0, 2)) @(negedge clk);
  endtask

  task automatic abort_txn();
    @(negedge clk);
    price = 4'($urandom); amount = 4'($urandom_range(1, 3)); money = 7'd127;
    mahcineAcc = 9'($urandom); supply = 4'd15;
    mode = 2'd1;
    @(negedge clk);
    mode = other_mode();
    @(negedge clk);
  endtask

  initial begin
    #1 check("reset_red", int'(redLight), 0);
    check("reset_supply", int'(supply_out), 0);
    check("reset_acc", int'(machineAcc_out), 0);
    @(negedge clk);
    #1 rst_n = 1'b1;

    purchase(2, 2, 20, 0, 11, 2);
    purchase(5, 3, 14, 0, 10, 2);
    purchase(3, 4, 12, 3, 4, 3);
    purchase(9, 0, 100, 17, 6, 2);
    purchase(1, 12, 100, 40, 11, 2);
    purchase(4, 3, 12, 7, 3, 2);
    purchase(7, 2, 30, 5, 9, 10);
    abort_txn();
    purchase(2, 2, 10, 30, 5, 2);

    // Asynchronous reset while the captured request sits in CALC.
    @(negedge clk);
    price = 4'd1; amount = 4'd1; money = 7'd50; mahcineAcc = 9'd9; supply = 4'd8;
    mode = 2'd1;
    @(posedge clk);
    #2 rst_n = 1'b0;
    q.delete();
    #1 check("async_reset_red", int'(redLight), 0);
    check("async_reset_supply", int'(supply_out), 0);
    check("async_reset_acc", int'(machineAcc_out), 0);
    @(negedge clk);
    mode = 2'd0;
    #1 rst_n = 1'b1;

    for (int n = 0; n < 250; n++) begin
      if ($urandom_range(0, 9) == 0) begin
        abort_txn();
      end else begin
        purchase($urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 127),
                 $urandom_range(0, 511), $urandom_range(0, 15), $urandom_range(2, 5));
      end
    end

    repeat (5) @(negedge clk);
    check("scoreboard_drained", q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
